morph_nxn: RTL and testbench

MORPH_NXN -- requirements
Module: morph_nxn

---
 rtl/morph_nxn.sv | 180 ++++++++++++++++++
 tb/tb_morph_nxn.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_nxn.sv
// Binary dilate/erode over a KSIZE x KSIZE bottom-right anchored window on a streaming raster.
// Optional MORPH_THRESH_EN adds a frame-sampled 8-bit threshold for foreground classification.
module morph_nxn #(
  parameter int unsigned DW    = 24,
  parameter int unsigned COL   = 1024,
  parameter int unsigned ROW   = 768,
  parameter int unsigned KSIZE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_de,
  input  logic          din_hsync,
  input  logic          din_vsync,
  input  logic [DW-1:0] din_data,
  input  logic          mode,
`ifdef MORPH_THRESH_EN
  input  logic [7:0]    thresh,
`endif
  output logic          dout_de,
  output logic          dout_hsync,
  output logic          dout_vsync,
  output logic [DW-1:0] dout_data
);

  localparam int unsigned CW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned RW  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned NLB = KSIZE - 1;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("morph_nxn: KSIZE must be 3 or 5");
  end

  logic            r_vs_prev;
  logic            w_vs_rise;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_mode;
  logic            w_fg;

  logic            r_lb   [NLB][COL];
  logic [KSIZE-1:0] w_cur;
  logic [KSIZE-2:0] r_hist [KSIZE];
  logic [KSIZE-1:0] w_win  [KSIZE];
  logic [KSIZE-1:0] w_rowred;

  logic [KSIZE-1:0] r_s1;
  logic             r_s1_mode;
  logic             r_s2;
  logic [DW-1:0]    r_dout;
  logic [2:0]       r_de_dly;
  logic [2:0]       r_hs_dly;
  logic [2:0]       r_vs_dly;

  assign w_vs_rise = din_vsync & ~r_vs_prev;

  // Foreground classification
`ifdef MORPH_THRESH_EN
  logic [7:0] r_thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh <= '0;
    end else if (w_vs_rise) begin
      r_thresh <= thresh;
    end
  end

  assign w_fg = (din_data[7:0] >= r_thresh);
`else
  assign w_fg = (din_data != '0);
`endif

  // Frame-level state: vsync edge detector, mode register, raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_mode    <= 1'b0;
    end else begin
      r_vs_prev <= din_vsync;
      if (w_vs_rise) begin
        r_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_vs_rise) begin
      r_col <= '0;
      r_row <= '0;
    end else if (din_de) begin
      if (r_col == CW'(COL - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(ROW - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers: r_lb[0] holds row r-1, r_lb[k] holds row r-1-k; no reset needed since
  // rows above the current frame's row 0 are masked below.
  always_ff @(posedge clk) begin
    if (din_de) begin
      r_lb[0][r_col] <= w_fg;
      for (int k = 1; k < NLB; k++) begin
        r_lb[k][r_col] <= r_lb[k-1][r_col];
      end
    end
  end

  always_comb begin
    w_cur    = '0;
    w_cur[0] = w_fg;
    for (int k = 1; k < KSIZE; k++) begin
      w_cur[k] = r_lb[k-1][r_col];
    end
  end

  // Horizontal history per window row; bit 0 is column c-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KSIZE; k++) begin
        r_hist[k] <= '0;
      end
    end else if (din_de) begin
      for (int k = 0; k < KSIZE; k++) begin
        r_hist[k] <= {r_hist[k][KSIZE-3:0], w_cur[k]};
      end
    end
  end

  // Window assembly with out-of-frame positions replaced by the neutral element of the
  // reduction (0 for OR, 1 for AND), then per-row reduction.
  always_comb begin
    for (int k = 0; k < KSIZE; k++) begin
      w_win[k] = '0;
      w_win[k][0] = (int'(r_row) >= k) ? w_cur[k] : r_mode;
      for (int j = 1; j < KSIZE; j++) begin
        w_win[k][j] = ((int'(r_row) >= k) && (int'(r_col) >= j)) ? r_hist[k][j-1] : r_mode;
      end
    end
  end

  always_comb begin
    w_rowred = '0;
    for (int k = 0; k < KSIZE; k++) begin
      w_rowred[k] = r_mode ? (&w_win[k]) : (|w_win[k]);
    end
  end

  // Three-stage output pipeline: row reduction, column reduction, output expansion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s1_mode <= 1'b0;
      r_s2      <= 1'b0;
      r_dout    <= '0;
      r_de_dly  <= '0;
      r_hs_dly  <= '0;
      r_vs_dly  <= '0;
    end else begin
      r_s1      <= w_rowred;
      r_s1_mode <= r_mode;
      r_s2      <= r_s1_mode ? (&r_s1) : (|r_s1);
      r_dout    <= r_de_dly[1] ? {DW{r_s2}} : '0;
      r_de_dly  <= {r_de_dly[1:0], din_de};
      r_hs_dly  <= {r_hs_dly[1:0], din_hsync};
      r_vs_dly  <= {r_vs_dly[1:0], din_vsync};
    end
  end

  assign dout_de    = r_de_dly[2];
  assign dout_hsync = r_hs_dly[2];
  assign dout_vsync = r_vs_dly[2];
  assign dout_data  = r_dout;

endmodule

// File: tb/tb_morph_nxn.sv
// Self-checking bench for morph_nxn: KSIZE=3 and KSIZE=5 instances against a frame-buffer model.
module tb_morph_nxn;
  localparam int DW  = 24;
  localparam int COL = 8;
  localparam int ROW = 6;
  localparam logic [DW-1:0] FG = 24'hFFFF80;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic [DW-1:0] d;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din_de, din_hsync, din_vsync;
  logic [DW-1:0] din_data;
  logic          mode_in;
  logic [7:0]    thresh_in;
  logic          de3, hs3, vs3, de5, hs5, vs5;
  logic [DW-1:0] d3, d5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morph_nxn #(.DW(DW), .COL(COL), .ROW(ROW), .KSIZE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din_de(din_de), .din_hsync(din_hsync),
    .din_vsync(din_vsync), .din_data(din_data), .mode(mode_in),
`ifdef MORPH_THRESH_EN
    .thresh(thresh_in),
`endif
    .dout_de(de3), .dout_hsync(hs3), .dout_vsync(vs3), .dout_data(d3)
  );

  morph_nxn #(.DW(DW), .COL(COL), .ROW(ROW), .KSIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .din_de(din_de), .din_hsync(din_hsync),
    .din_vsync(din_vsync), .din_data(din_data), .mode(mode_in),
`ifdef MORPH_THRESH_EN
    .thresh(thresh_in),
`endif
    .dout_de(de5), .dout_hsync(hs5), .dout_vsync(vs5), .dout_data(d5)
  );

  // Reference model: current-frame foreground image plus 3-deep expected output history
  logic [DW-1:0] pix [ROW][COL];
  bit            img [ROW][COL];
  bit            cap3 [ROW][COL];
  bit            cap5 [ROW][COL];
  out_t          h3 [3];
  out_t          h5 [3];
  int            mcol, mrow;
  bit            mmode, mvs_prev;
  logic [7:0]    mthresh;

  function automatic bit is_fg(input logic [DW-1:0] v);
`ifdef MORPH_THRESH_EN
    return v[7:0] >= mthresh;
`else
    return v != '0;
`endif
  endfunction

  function automatic bit win(input int r, input int c, input int k, input bit m);
    bit acc = m;
    for (int dr = 0; dr < k; dr++) begin
      for (int dc = 0; dc < k; dc++) begin
        int rr = r - dr;
        int cc = c - dc;
        bit b = (rr < 0 || cc < 0) ? m : img[rr][cc];
        acc = m ? (acc & b) : (acc | b);
      end
    end
    return acc;
  endfunction

  initial begin
    mcol = 0; mrow = 0; mmode = 0; mvs_prev = 0; mthresh = '0;
    for (int i = 0; i < 3; i++) begin h3[i] = '0; h5[i] = '0; end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mcol = 0; mrow = 0; mmode = 0; mvs_prev = 0; mthresh = '0;
        for (int i = 0; i < 3; i++) begin h3[i] = '0; h5[i] = '0; end
      end else begin
        out_t e3, e5;
        e3 = '0;
        e3.de = din_de; e3.hs = din_hsync; e3.vs = din_vsync;
        e5 = e3;
        if (din_vsync && !mvs_prev) begin
          mcol = 0; mrow = 0; mmode = mode_in; mthresh = thresh_in;
        end else if (din_de) begin
          img[mrow][mcol] = is_fg(din_data);
          e3.d = {DW{win(mrow, mcol, 3, mmode)}};
          e5.d = {DW{win(mrow, mcol, 5, mmode)}};
          mcol++;
          if (mcol == COL) begin
            mcol = 0;
            mrow = (mrow == ROW - 1) ? 0 : mrow + 1;
          end
        end
        h3[2] = h3[1]; h3[1] = h3[0]; h3[0] = e3;
        h5[2] = h5[1]; h5[1] = h5[0]; h5[0] = e5;
        mvs_prev = din_vsync;
      end
    end
  end

  // Per-cycle stream compare plus capture of each output frame for literal checks
  initial begin
    int  orow, ocol;
    bit  ovs_prev;
    out_t exp3, exp5, act3, act5;
    orow = 0; ocol = 0; ovs_prev = 0;
    forever begin
      @(negedge clk);
      exp3 = rst_n ? h3[2] : '0;
      exp5 = rst_n ? h5[2] : '0;
      act3 = {de3, hs3, vs3, d3};
      act5 = {de5, hs5, vs5, d5};
      checks++;
      if (act3 !== exp3) begin
        errors++;
        $display("FAIL k3_stream t=%0t got %h want %h", $time, act3, exp3);
      end
      checks++;
      if (act5 !== exp5) begin
        errors++;
        $display("FAIL k5_stream t=%0t got %h want %h", $time, act5, exp5);
      end
      if (!rst_n) begin
        orow = 0; ocol = 0; ovs_prev = 0;
      end else begin
        if (vs3 && !ovs_prev) begin orow = 0; ocol = 0; end
        if (de3) begin
          cap3[orow][ocol] = (d3 != '0);
          cap5[orow][ocol] = (d5 != '0);
          ocol++;
          if (ocol == COL) begin
            ocol = 0;
            orow = (orow == ROW - 1) ? 0 : orow + 1;
          end
        end
        ovs_prev = vs3;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int cnt3();
    int n = 0;
    for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) n += int'(cap3[r][c]);
    return n;
  endfunction

  function automatic int cnt5();
    int n = 0;
    for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) n += int'(cap5[r][c]);
    return n;
  endfunction

  task automatic step(input logic de, input logic hs, input logic vs, input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    din_de = de; din_hsync = hs; din_vsync = vs; din_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) pix[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        case ($urandom_range(0, 4))
          0, 1:    pix[r][c] = '0;
          2:       pix[r][c] = 24'h00007F;
          3:       pix[r][c] = 24'h000080;
          default: pix[r][c] = DW'($urandom);
        endcase
      end
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, int'({de3, hs3, vs3, de5, hs5, vs5, (d3 != '0), (d5 != '0)}), 0);
  endtask

  // Sends one frame with random de stalls; abort_row >= 0 pulls reset partway through that row
  task automatic send_frame(input bit with_vs, input bit m0, input bit flip_mid,
                            input int abort_row);
    mode_in = m0;
    if (with_vs) begin
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      idle(2);
    end
    for (int r = 0; r < ROW; r++) begin
      if (flip_mid && r == ROW / 2) mode_in = ~mode_in;
      step(1'b0, 1'b1, 1'b0, '0);
      idle(1);
      for (int c = 0; c < COL; c++) begin
        if (r == abort_row && c == 3) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          din_de = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0; din_data = '0;
          idle(3);
          chk_reset_outputs("abort_reset_outputs");
          @(posedge clk);
          #2;
          rst_n = 1'b1;
          idle(2);
          return;
        end
        while ($urandom_range(0, 3) == 0) idle(1);
        step(1'b1, 1'b0, 1'b0, pix[r][c]);
      end
      idle(2);
    end
    idle(5);
  endtask

  initial begin
    rst_n = 1'b0;
    din_de = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0; din_data = '0;
    mode_in = 1'b0; thresh_in = 8'h80;
    idle(4);
    chk_reset_outputs("reset_outputs");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);

    // Dilate, single foreground pixel at (2,3)
    fill('0); pix[2][3] = FG;
    send_frame(1'b1, 1'b0, 1'b0, -1);
    chk("dil3_count", cnt3(), 9);
    chk("dil3_r2c3", int'(cap3[2][3]), 1);
    chk("dil3_r4c5", int'(cap3[4][5]), 1);
    chk("dil3_r1c3", int'(cap3[1][3]), 0);
    chk("dil3_r2c2", int'(cap3[2][2]), 0);
    chk("dil3_r5c5", int'(cap3[5][5]), 0);
    chk("dil5_count", cnt5(), 20);

    // Erode, all foreground except (2,3)
    fill(FG); pix[2][3] = '0;
    send_frame(1'b1, 1'b1, 1'b0, -1);
    chk("ero3_zeros", ROW * COL - cnt3(), 9);
    chk("ero3_r0c0", int'(cap3[0][0]), 1);
    chk("ero3_r3c4", int'(cap3[3][4]), 0);
    chk("ero3_r5c6", int'(cap3[5][6]), 1);
    chk("ero5_zeros", ROW * COL - cnt5(), 20);

    // All-ones frame followed by a single pixel at (0,0): no leakage from the previous frame
    fill(FG);
    send_frame(1'b1, 1'b0, 1'b0, -1);
    fill('0); pix[0][0] = FG;
    send_frame(1'b1, 1'b0, 1'b0, -1);
    chk("leak5_count", cnt5(), 25);
    chk("leak5_r4c4", int'(cap5[4][4]), 1);
    chk("leak5_r5c0", int'(cap5[5][0]), 0);
    chk("leak5_r0c5", int'(cap5[0][5]), 0);
    chk("leak3_count", cnt3(), 9);

    // Mode flips mid-frame: this frame stays dilate, the next one erodes
    fill('0); pix[2][3] = FG;
    send_frame(1'b1, 1'b0, 1'b1, -1);
    chk("flip_f1_count", cnt3(), 9);
    fill(FG); pix[2][3] = '0;
    send_frame(1'b1, mode_in, 1'b0, -1);
    chk("flip_f2_zeros", ROW * COL - cnt3(), 9);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      send_frame(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // Reset mid-frame, then a frame with no vsync starting at (0,0) in dilate mode
    fill_rand();
    send_frame(1'b1, 1'b1, 1'b0, 3);
    fill('0); pix[0][0] = FG;
    send_frame(1'b0, 1'b1, 1'b0, -1);
    chk("post_reset_count", cnt3(), 9);
    chk("post_reset_r2c2", int'(cap3[2][2]), 1);

`ifdef MORPH_THRESH_EN
    thresh_in = 8'h80;
    fill('0); pix[1][1] = 24'h00007F;
    send_frame(1'b1, 1'b0, 1'b0, -1);
    chk("thresh_7f_count", cnt3(), 0);
    pix[1][1] = 24'h000080;
    send_frame(1'b1, 1'b0, 1'b0, -1);
    chk("thresh_80_count", cnt3(), 9);
`endif

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
